// File: rtl/qmem_pkg.sv
// Shared types and constants for the QMEM RAM responder: FSM states, wait-counter
// width and byte-lane geometry.
package qmem_pkg;

   localparam int CNT_W     = 4;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;
   localparam int NUM_LANES = 4;
   localparam int LANE_W    = 8;
   localparam int LANE_LO   = 0;
   localparam int LANE_HI   = NUM_LANES - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   function automatic int lane_lsb(input int lane);
      return lane * LANE_W;
   endfunction

endpackage

// File: rtl/qmem_ram_responder_if.sv
// QMEM-style CPU bus: request (cs/we/sel/adr/dat_w) from the CPU, dat_r/ack back.
interface qmem_ram_responder_if #(
   parameter int AW = 24
);
   logic          cs;
   logic          we;
   logic [3:0]    sel;
   logic [AW-1:0] adr;
   logic [31:0]   dat_w;
   logic [31:0]   dat_r;
   logic          ack;

   modport master (output cs, we, sel, adr, dat_w, input  dat_r, ack);
   modport slave  (input  cs, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/qmem_ram_sp.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port.
module qmem_ram_sp
   import qmem_pkg::*;
#(
   parameter int MAW = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_en,
   input  logic [NUM_LANES-1:0] wr_be,
   input  logic [MAW-1:0]       addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [31:0] mem [2**MAW];

   // NOTE: the storage array has no reset; contents must survive rst and map onto block RAM.
   always_ff @(posedge clk) begin
      for (int l = LANE_LO; l <= LANE_HI; l++) begin
         if (wr_be[l]) mem[addr][lane_lsb(l) +: LANE_W] <= wdata[lane_lsb(l) +: LANE_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)        rdata <= '0;
      else if (rd_en) rdata <= mem[addr];
   end

endmodule

// File: rtl/qmem_ram_responder.sv
// QMEM bus responder backed by an on-chip RAM with programmable read/write wait states.
// Define QMEM_RD_HIT_EN to add a one-entry read buffer that acks repeat reads in one cycle.
module qmem_ram_responder
   import qmem_pkg::*;
#(
   parameter int AW      = 24,
   parameter int MAW     = 12,
   parameter int RD_WAIT = 1,
   parameter int WR_WAIT = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   qmem_ram_responder_if.slave     bus
);

   if (RD_WAIT < 0 || RD_WAIT > CNT_MAX) begin : g_bad_rd_wait
      $error("RD_WAIT must be within 0..15");
   end
   if (WR_WAIT < 0 || WR_WAIT > CNT_MAX) begin : g_bad_wr_wait
      $error("WR_WAIT must be within 0..15");
   end
   if (AW < MAW + 2) begin : g_bad_aw
      $error("AW too narrow for the RAM word index");
   end

   state_e               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic                 req_we;
   logic [NUM_LANES-1:0] req_sel;
   logic [MAW-1:0]       req_idx;
   logic [31:0]          req_dat;
   logic [MAW-1:0]       bus_idx;
   logic                 mem_go;
   logic                 rd_hit;
   logic [31:0]          ram_q;
   logic                 unused_adr;

   // Upper address bits alias onto the same RAM; byte offset is ignored for word accesses.
   assign bus_idx    = bus.adr[MAW+1:2];
   assign unused_adr = ^{bus.adr[AW-1:MAW+2], bus.adr[1:0]};

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_IDLE) begin
         req_we  <= bus.we;
         req_sel <= bus.sel;
         req_idx <= bus_idx;
         req_dat <= bus.dat_w;
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_nxt = state;
      cnt_nxt   = cnt;
      mem_go    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.cs) begin
               cnt_nxt   = bus.we ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
               state_nxt = rd_hit ? ST_ACK : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!bus.cs) begin
               state_nxt = ST_IDLE;
            end else if (cnt == '0) begin
               state_nxt = ST_ACK;
               mem_go    = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_ACK:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.ack   = (state == ST_ACK);
   assign bus.dat_r = ram_q;

`ifdef QMEM_RD_HIT_EN
   logic           hit_valid;
   logic [MAW-1:0] hit_idx;

   // Any completed write may alias the buffered word, so it simply invalidates the entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_valid <= 1'b0;
      end else if (mem_go) begin
         hit_valid <= !req_we;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_go && !req_we) hit_idx <= req_idx;
   end

   assign rd_hit = hit_valid && !bus.we && (bus_idx == hit_idx);
`else
   assign rd_hit = 1'b0;
`endif

   qmem_ram_sp #(.MAW(MAW)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .rd_en (mem_go && !req_we && !rst),
      .wr_be (req_sel & {NUM_LANES{mem_go && req_we && !rst}}),
      .addr  (req_idx),
      .wdata (req_dat),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_qmem_ram_responder.sv
// Self-checking bench for qmem_ram_responder: directed cases plus randomized traffic
// compared every cycle against a transaction-level memory model.
module tb_qmem_ram_responder;

   localparam int AW      = 24;
   localparam int MAW     = 12;
   localparam int RD_WAIT = 1;
   localparam int WR_WAIT = 2;
`ifdef QMEM_RD_HIT_EN
   localparam bit HIT_EN = 1'b1;
`else
   localparam bit HIT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   qmem_ram_responder_if #(.AW(AW)) bus ();

   qmem_ram_responder #(
      .AW(AW), .MAW(MAW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // Transaction-level model: word memory, expected ack cycles, read register, hit entry.
   logic [31:0] mem_m [int];
   bit          exp_ack [int];
   logic [31:0] model_dat_r = '0;
   bit          hv_m = 1'b0;
   int          hidx_m = 0;
   int          last_ack_cyc = -1;
   int          ack_log [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("ack", {31'b0, bus.ack}, {31'b0, exp_ack.exists(cyc) != 0});
         check("dat_r", bus.dat_r, model_dat_r);
         if (bus.ack === 1'b1) begin
            last_ack_cyc = cyc;
            ack_log.push_back(cyc);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic int word_idx(input logic [AW-1:0] a);
      return int'(a[MAW+1:2]);
   endfunction

   function automatic bit model_hit(input bit w, input logic [AW-1:0] a);
      return HIT_EN && hv_m && !w && (word_idx(a) == hidx_m);
   endfunction

   // Starts in a cycle where the responder is idle; returns in the cycle after ack, cs still high.
   task automatic access(input bit w, input logic [3:0] s, input logic [AW-1:0] a,
                         input logic [31:0] d, output int c0);
      int  lat;
      int  idx;
      bit  hit;
      idx = word_idx(a);
      hit = model_hit(w, a);
      lat = w ? 2 + WR_WAIT : (hit ? 1 : 2 + RD_WAIT);
      c0  = cyc;
      exp_ack[cyc + lat] = 1'b1;
      bus.cs = 1'b1; bus.we = w; bus.sel = s; bus.adr = a; bus.dat_w = d;
      repeat (lat) next_cycle();
      if (w) begin
         if (!mem_m.exists(idx)) mem_m[idx] = 'x;
         for (int l = 0; l < 4; l++)
            if (s[l]) mem_m[idx][8*l +: 8] = d[8*l +: 8];
         hv_m = 1'b0;
      end else if (!hit) begin
         model_dat_r = mem_m.exists(idx) ? mem_m[idx] : 'x;
         hv_m   = 1'b1;
         hidx_m = idx;
      end
      next_cycle();
   endtask

   task automatic abort_access(input bit w, input logic [3:0] s, input logic [AW-1:0] a,
                               input logic [31:0] d, input int hold);
      bus.cs = 1'b1; bus.we = w; bus.sel = s; bus.adr = a; bus.dat_w = d;
      repeat (hold) next_cycle();
      bus.cs = 1'b0;
      repeat (4 + RD_WAIT + WR_WAIT) next_cycle();
   endtask

   task automatic idle(input int n);
      bus.cs = 1'b0;
      repeat (n) next_cycle();
   endtask

   initial begin
      int c0, c1, saved, lat, idx;
      bit w;
      logic [3:0]    s;
      logic [AW-1:0] a;
      logic [31:0]   d;

      bus.cs = 1'b0; bus.we = 1'b0; bus.sel = '0; bus.adr = '0; bus.dat_w = '0;
      repeat (3) next_cycle();
      chk_en = 1'b1;
      check("reset_ack", {31'b0, bus.ack}, 32'd0);
      check("reset_dat_r", bus.dat_r, 32'd0);
      rst = 1'b0;
      idle(2);

      // Full write then read: ack three cycles after C0, data returned.
      access(1'b1, 4'hF, 24'h000010, 32'hDEADBEEF, c0);
      check("wr_latency", 32'(last_ack_cyc - c0), 32'(2 + WR_WAIT));
      idle(1);
      access(1'b0, 4'hF, 24'h000010, 32'h0, c0);
      check("rd_latency", 32'(last_ack_cyc - c0), 32'd3);
      check("rd_data", bus.dat_r, 32'hDEADBEEF);
      idle(1);

      // Single-lane write merges into the existing word.
      access(1'b1, 4'b0100, 24'h000010, 32'h00AA0000, c0);
      idle(1);
      access(1'b0, 4'hF, 24'h000010, 32'h0, c0);
      check("byte_merge", bus.dat_r, 32'hDEAABEEF);
      idle(1);

      // Address bit 14 lies above the word index and aliases onto word 0.
      access(1'b1, 4'hF, 24'h004000, 32'h12345678, c0);
      idle(1);
      access(1'b0, 4'hF, 24'h000000, 32'h0, c0);
      check("alias", bus.dat_r, 32'h12345678);
      idle(1);

      // Aborted read and aborted write leave no ack and no RAM change.
      saved = last_ack_cyc;
      abort_access(1'b0, 4'hF, 24'h000010, 32'h0, 1);
      check("abort_rd_no_ack", 32'(last_ack_cyc), 32'(saved));
      abort_access(1'b1, 4'hF, 24'h000010, 32'hFFFFFFFF, 3);
      check("abort_wr_no_ack", 32'(last_ack_cyc), 32'(saved));
      access(1'b0, 4'hF, 24'h000010, 32'h0, c0);
      check("abort_wr_ram", bus.dat_r, 32'hDEAABEEF);
      idle(1);

      // Back-to-back reads with cs held throughout.
      access(1'b1, 4'hF, 24'h000004, 32'h0BADF00D, c0);
      access(1'b1, 4'hF, 24'h000008, 32'hCAFEF00D, c0);
      ack_log.delete();
      access(1'b0, 4'hF, 24'h000000, 32'h0, c0);
      access(1'b0, 4'hF, 24'h000004, 32'h0, c0);
      access(1'b0, 4'hF, 24'h000008, 32'h0, c0);
      idle(1);
      check("b2b_count", 32'(ack_log.size()), 32'd3);
      if (ack_log.size() == 3) begin
         check("b2b_gap01", 32'(ack_log[1] - ack_log[0]), 32'd4);
         check("b2b_gap12", 32'(ack_log[2] - ack_log[1]), 32'd4);
      end
      check("b2b_last_data", bus.dat_r, 32'hCAFEF00D);

      // Repeat read takes the buffer path when enabled; a write restores full latency.
      access(1'b1, 4'hF, 24'h000020, 32'hA5A5F00F, c0);
      idle(1);
      access(1'b0, 4'hF, 24'h000020, 32'h0, c0);
      access(1'b0, 4'hF, 24'h000020, 32'h0, c0);
      check("hit_latency", 32'(last_ack_cyc - c0), HIT_EN ? 32'd1 : 32'd3);
      check("hit_data", bus.dat_r, 32'hA5A5F00F);
      access(1'b1, 4'hF, 24'h000030, 32'h11112222, c0);
      access(1'b0, 4'hF, 24'h000020, 32'h0, c0);
      check("post_wr_latency", 32'(last_ack_cyc - c0), 32'd3);
      idle(1);

      // Reset on the cycle the write would commit: no ack, word keeps its old value.
      access(1'b1, 4'hF, 24'h000040, 32'h55AA55AA, c0);
      idle(1);
      saved = last_ack_cyc;
      bus.cs = 1'b1; bus.we = 1'b1; bus.sel = 4'hF; bus.adr = 24'h000040; bus.dat_w = 32'h0;
      repeat (1 + WR_WAIT) next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      bus.cs = 1'b0;
      model_dat_r = '0;
      hv_m = 1'b0;
      idle(6);
      check("rst_no_ack", 32'(last_ack_cyc), 32'(saved));
      access(1'b0, 4'hF, 24'h000040, 32'h0, c0);
      check("rst_ram_kept", bus.dat_r, 32'h55AA55AA);
      idle(1);

      // Randomized traffic over a small aliased window.
      for (int i = 64; i < 80; i++) begin
         access(1'b1, 4'hF, AW'(i * 4), $urandom, c0);
      end
      idle(1);
      for (int i = 0; i < 300; i++) begin
         w   = 1'($urandom_range(0, 1));
         idx = 64 + int'($urandom_range(0, 15));
         a   = {10'($urandom), 12'(idx), 2'($urandom)};
         s   = w ? 4'($urandom) : 4'hF;
         d   = $urandom;
         if ($urandom_range(0, 7) == 0 && !model_hit(w, a)) begin
            lat = w ? 2 + WR_WAIT : 2 + RD_WAIT;
            abort_access(w, s, a, d, int'($urandom_range(1, lat - 1)));
         end else begin
            access(w, s, a, d, c1);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
         end
      end
      idle(4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
